// File: rtl/hazard_stall_unit_pkg.sv
// Shared CPU types for the pipeline control blocks: register index, hazard FSM states,
// and the packed per-latch enable/flush control word with its canned values.
package cpu_types_pkg;

   localparam int REG_W = 5;

   typedef logic [REG_W-1:0] regbits_t;

   localparam regbits_t ZERO_REG = '0;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DWAIT = 2'd1,
      FLUSH = 2'd2,
      HALT  = 2'd3
   } hz_state_t;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic memwb_en;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_flush;
   } hz_ctrl_t;

   localparam hz_ctrl_t CTRL_NONE     = 8'b00000_000;
   localparam hz_ctrl_t CTRL_ALL      = 8'b11111_000;
   localparam hz_ctrl_t CTRL_REDIRECT = 8'b11111_111;
   // Load-use: hold PC/IFID, clock a bubble into IDEX, let EX and MEM drain.
   localparam hz_ctrl_t CTRL_LOADUSE  = 8'b00111_010;
   // I-miss: retire the MEM result and clear EXMEM so it is not retired twice.
   localparam hz_ctrl_t CTRL_IMISS    = 8'b00001_001;
   localparam hz_ctrl_t CTRL_HALT     = 8'b00001_000;

   function automatic logic reg_dep(input regbits_t dst, input regbits_t rs, input regbits_t rt);
      return (dst != ZERO_REG) && ((dst == rs) || (dst == rt));
   endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Hazard unit signal bundle: hu modport faces the control block, tb the datapath/bench.
// Statistic counters exist only when HAZARD_STATS_EN is defined.
interface hazard_unit_if #(parameter int STALL_CNT_W = 16);
   import cpu_types_pkg::*;

   if (STALL_CNT_W < 1) begin : g_bad_width
      $error("STALL_CNT_W must be at least 1");
   end

   regbits_t rs_id;
   regbits_t rt_id;
   regbits_t reg_wr_ex;
   logic     memread_ex;
   logic     dmemren_mem;
   logic     dmemwen_mem;
   logic     ihit;
   logic     dhit;
   logic     pc_redirect_mem;
   logic     halt_mem;

   logic     pc_en;
   logic     ifid_en;
   logic     idex_en;
   logic     exmem_en;
   logic     memwb_en;
   logic     ifid_flush;
   logic     idex_flush;
   logic     exmem_flush;
   logic     halted;
`ifdef HAZARD_STATS_EN
   logic [STALL_CNT_W-1:0] loaduse_cnt;
   logic [STALL_CNT_W-1:0] dwait_cnt;
   logic [STALL_CNT_W-1:0] flush_cnt;
`endif

   modport hu (
      input  rs_id, rt_id, reg_wr_ex, memread_ex, dmemren_mem, dmemwen_mem,
             ihit, dhit, pc_redirect_mem, halt_mem,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, halted
`ifdef HAZARD_STATS_EN
      , output loaduse_cnt, dwait_cnt, flush_cnt
`endif
   );

   modport tb (
      output rs_id, rt_id, reg_wr_ex, memread_ex, dmemren_mem, dmemwen_mem,
             ihit, dhit, pc_redirect_mem, halt_mem,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, halted
`ifdef HAZARD_STATS_EN
      , input loaduse_cnt, dwait_cnt, flush_cnt
`endif
   );

endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter for stall statistics; counts one per cycle with inc high.
// Sticks at all-ones rather than wrapping.
module hz_sat_counter #(
   parameter int W = 16
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush control for the 5-stage pipeline: load-use bubbles, D-cache waits, redirect flushes, halt.
// Outputs are combinational from state and stage inputs; HAZARD_STATS_EN adds stall counters.
module hazard_stall_unit
   import cpu_types_pkg::*;
#(
   parameter int STALL_CNT_W = 16
) (
   input logic        CLK,
   input logic        nRST,
   hazard_unit_if.hu  hif
);

   if (STALL_CNT_W < 1) begin : g_bad_width
      $error("STALL_CNT_W must be at least 1");
   end

   hz_state_t state;
   hz_state_t state_nxt;
   hz_state_t run_nxt;
   hz_ctrl_t  ctrl;
   hz_ctrl_t  run_ctrl;
   hz_ctrl_t  ctrl_out;

   logic mem_req;
   logic mem_ok;
   logic adv;
   logic load_use;

   assign mem_req  = hif.dmemren_mem | hif.dmemwen_mem;
   assign mem_ok   = !mem_req | hif.dhit;
   assign adv      = hif.ihit & mem_ok;
   assign load_use = hif.memread_ex & reg_dep(hif.reg_wr_ex, hif.rs_id, hif.rt_id);

   // Decision rules used in RUN, and reused by DWAIT on the dhit cycle so a
   // completed access costs no extra cycle.
   always_comb begin
      run_ctrl = CTRL_NONE;
      run_nxt  = RUN;
      if (hif.halt_mem && mem_ok) begin
         run_ctrl = CTRL_HALT;
         run_nxt  = HALT;
      end else if (mem_req && !hif.dhit) begin
         run_nxt = hif.pc_redirect_mem ? FLUSH : DWAIT;
      end else if (!hif.ihit) begin
         run_ctrl = CTRL_IMISS;
      end else if (hif.pc_redirect_mem) begin
         run_ctrl = CTRL_REDIRECT;
      end else if (load_use) begin
         run_ctrl = CTRL_LOADUSE;
      end else begin
         run_ctrl = CTRL_ALL;
      end
   end

   always_comb begin
      ctrl      = CTRL_NONE;
      state_nxt = state;
      unique case (state)
         RUN: begin
            ctrl      = run_ctrl;
            state_nxt = run_nxt;
         end
         DWAIT: begin
            if (hif.dhit) begin
               ctrl      = run_ctrl;
               state_nxt = run_nxt;
            end else if (hif.pc_redirect_mem) begin
               state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            if (adv) begin
               ctrl      = CTRL_REDIRECT;
               state_nxt = RUN;
            end
         end
         HALT: begin
            ctrl      = CTRL_NONE;
            state_nxt = HALT;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Reset forces every latch control low without waiting for a clock.
   assign ctrl_out = nRST ? ctrl : CTRL_NONE;

   assign hif.pc_en       = ctrl_out.pc_en;
   assign hif.ifid_en     = ctrl_out.ifid_en;
   assign hif.idex_en     = ctrl_out.idex_en;
   assign hif.exmem_en    = ctrl_out.exmem_en;
   assign hif.memwb_en    = ctrl_out.memwb_en;
   assign hif.ifid_flush  = ctrl_out.ifid_flush;
   assign hif.idex_flush  = ctrl_out.idex_flush;
   assign hif.exmem_flush = ctrl_out.exmem_flush;
   assign hif.halted      = nRST && (state == HALT);

`ifdef HAZARD_STATS_EN
   logic live;
   logic lu_inc;
   logic dw_inc;
   logic fl_inc;

   assign live   = (state != HALT);
   assign lu_inc = live && (ctrl == CTRL_LOADUSE);
   // Only a redirect ever clears IFID, so that bit marks a redirect flush.
   assign fl_inc = live && ctrl.ifid_flush;
   assign dw_inc = ((state == RUN) && mem_req && !hif.dhit) ||
                   ((state == DWAIT) && !hif.dhit);

   hz_sat_counter #(.W(STALL_CNT_W)) u_lu_cnt (
      .CLK(CLK), .nRST(nRST), .inc(lu_inc), .cnt(hif.loaduse_cnt)
   );
   hz_sat_counter #(.W(STALL_CNT_W)) u_dw_cnt (
      .CLK(CLK), .nRST(nRST), .inc(dw_inc), .cnt(hif.dwait_cnt)
   );
   hz_sat_counter #(.W(STALL_CNT_W)) u_fl_cnt (
      .CLK(CLK), .nRST(nRST), .inc(fl_inc), .cnt(hif.flush_cnt)
   );
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: single-cycle RUN decisions from a table,
// then hand-written D-miss, redirect-in-wait, halt and reset sequences.
module tb_hazard_stall_unit;
   import cpu_types_pkg::*;

   localparam logic [7:0] E_NONE = 8'h00;
   localparam logic [7:0] E_ALL  = 8'hF8;
   localparam logic [7:0] E_LU   = 8'h3A;
   localparam logic [7:0] E_RED  = 8'hFF;
   localparam logic [7:0] E_IMS  = 8'h09;
   localparam logic [7:0] E_HLT  = 8'h08;

   logic CLK = 1'b0;
   logic nRST;
   always #5 CLK = ~CLK;

   hazard_unit_if #(.STALL_CNT_W(16)) hif ();

   hazard_stall_unit #(.STALL_CNT_W(16)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .hif  (hif.hu)
   );

   logic [7:0] outs;
   assign outs = {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en,
                  hif.ifid_flush, hif.idex_flush, hif.exmem_flush};

   typedef struct {
      logic [4:0] rs, rt, rw;
      logic       mr, ren, wen, ih, dh, red;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[14];
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rw,
                        input logic mr, input logic ren, input logic wen,
                        input logic ih, input logic dh, input logic red, input logic hl);
      hif.rs_id = rs;  hif.rt_id = rt;  hif.reg_wr_ex = rw;
      hif.memread_ex = mr;  hif.dmemren_mem = ren;  hif.dmemwen_mem = wen;
      hif.ihit = ih;  hif.dhit = dh;  hif.pc_redirect_mem = red;  hif.halt_mem = hl;
   endtask

   // Compare outputs mid-cycle, then advance to just after the next rising edge.
   task automatic cyc(input string name, input logic [8:0] exp);
      @(negedge CLK);
      check(name, {hif.halted, outs}, exp);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      tbl[0]  = '{rs:5'd1, rt:5'd2, rw:5'd3, mr:0, ren:0, wen:0, ih:1, dh:0, red:0, exp:E_ALL};
      tbl[1]  = '{rs:5'd5, rt:5'd2, rw:5'd5, mr:1, ren:0, wen:0, ih:1, dh:0, red:0, exp:E_LU};
      tbl[2]  = '{rs:5'd6, rt:5'd7, rw:5'd0, mr:0, ren:0, wen:0, ih:1, dh:0, red:0, exp:E_ALL};
      tbl[3]  = '{rs:5'd1, rt:5'd9, rw:5'd9, mr:1, ren:0, wen:0, ih:1, dh:0, red:0, exp:E_LU};
      tbl[4]  = '{rs:5'd0, rt:5'd0, rw:5'd0, mr:1, ren:0, wen:0, ih:1, dh:0, red:0, exp:E_ALL};
      tbl[5]  = '{rs:5'd3, rt:5'd4, rw:5'd7, mr:1, ren:0, wen:0, ih:1, dh:0, red:0, exp:E_ALL};
      tbl[6]  = '{rs:5'd7, rt:5'd1, rw:5'd7, mr:0, ren:0, wen:0, ih:1, dh:0, red:0, exp:E_ALL};
      tbl[7]  = '{rs:5'd1, rt:5'd2, rw:5'd3, mr:0, ren:0, wen:0, ih:1, dh:0, red:1, exp:E_RED};
      tbl[8]  = '{rs:5'd5, rt:5'd2, rw:5'd5, mr:1, ren:0, wen:0, ih:1, dh:0, red:1, exp:E_RED};
      tbl[9]  = '{rs:5'd1, rt:5'd2, rw:5'd3, mr:0, ren:0, wen:0, ih:0, dh:0, red:0, exp:E_IMS};
      tbl[10] = '{rs:5'd5, rt:5'd2, rw:5'd5, mr:1, ren:0, wen:0, ih:0, dh:0, red:0, exp:E_IMS};
      tbl[11] = '{rs:5'd1, rt:5'd2, rw:5'd3, mr:0, ren:1, wen:0, ih:1, dh:1, red:0, exp:E_ALL};
      tbl[12] = '{rs:5'd1, rt:5'd8, rw:5'd8, mr:1, ren:0, wen:1, ih:1, dh:1, red:0, exp:E_LU};
      tbl[13] = '{rs:5'd1, rt:5'd2, rw:5'd3, mr:0, ren:1, wen:0, ih:0, dh:1, red:0, exp:E_IMS};

      // Reset: inputs would otherwise enable everything.
      nRST = 1'b0;
      drive(5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 0, 0, 0);
      #12;
      check("reset_outputs", {hif.halted, outs}, 9'h000);
`ifdef HAZARD_STATS_EN
      check("reset_lu_cnt", hif.loaduse_cnt, 0);
`endif
      @(posedge CLK); #1;
      nRST = 1'b1;

      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].rs, tbl[i].rt, tbl[i].rw, tbl[i].mr, tbl[i].ren, tbl[i].wen,
               tbl[i].ih, tbl[i].dh, tbl[i].red, 1'b0);
         cyc($sformatf("vec%0d", i), {1'b0, tbl[i].exp});
      end
`ifdef HAZARD_STATS_EN
      check("loaduse_cnt", hif.loaduse_cnt, 3);
`endif

      // D-miss of 3 cycles: frozen 3 cycles, advance on dhit, then back in RUN.
      for (int i = 0; i < 3; i++) begin
         drive(5'd1, 5'd2, 5'd3, 0, 1, 0, 1, 0, 0, 0);
         cyc($sformatf("dmiss_wait%0d", i), {1'b0, E_NONE});
      end
      drive(5'd1, 5'd2, 5'd3, 0, 1, 0, 1, 1, 0, 0);
      cyc("dmiss_hit", {1'b0, E_ALL});
      drive(5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 0, 0, 0);
      cyc("dmiss_after", {1'b0, E_ALL});
`ifdef HAZARD_STATS_EN
      check("dwait_cnt", hif.dwait_cnt, 3);
`endif

      // Redirect arriving mid-wait: flush owed until the access completes.
      drive(5'd1, 5'd2, 5'd3, 0, 1, 0, 1, 0, 0, 0);
      cyc("rdw_miss", {1'b0, E_NONE});
      drive(5'd1, 5'd2, 5'd3, 0, 1, 0, 1, 0, 1, 0);
      cyc("rdw_redirect", {1'b0, E_NONE});
      drive(5'd1, 5'd2, 5'd3, 0, 1, 0, 1, 1, 1, 0);
      cyc("rdw_hit_flush", {1'b0, E_RED});
      drive(5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 0, 0, 0);
      cyc("rdw_after", {1'b0, E_ALL});
`ifdef HAZARD_STATS_EN
      check("flush_cnt", hif.flush_cnt, 3);
      check("dwait_cnt2", hif.dwait_cnt, 5);
`endif

      // Halt: one MEM retire, then absorbing with everything frozen.
      drive(5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 0, 0, 1);
      cyc("halt_retire", {1'b0, E_HLT});
      for (int i = 0; i < 3; i++) begin
         drive(5'd5, 5'd2, 5'd5, 1, 0, 0, 1, 0, i == 1, 0);
         cyc($sformatf("halted%0d", i), {1'b1, E_NONE});
      end
`ifdef HAZARD_STATS_EN
      check("halt_freeze_lu", hif.loaduse_cnt, 3);
      check("halt_freeze_fl", hif.flush_cnt, 3);
`endif

      // Reset out of HALT.
      nRST = 1'b0;
      #1;
      check("halt_reset", {hif.halted, outs}, 9'h000);
`ifdef HAZARD_STATS_EN
      check("reset_dw_cnt", hif.dwait_cnt, 0);
`endif
      @(posedge CLK); #1;
      nRST = 1'b1;

      // Enter FLUSH directly from RUN, then reset asynchronously while in it.
      drive(5'd1, 5'd2, 5'd3, 0, 1, 0, 1, 0, 1, 0);
      cyc("flush_enter", {1'b0, E_NONE});
      drive(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 0, 0);
      cyc("flush_hold", {1'b0, E_NONE});
      #2;
      nRST = 1'b0;
      drive(5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 0, 0, 0);
      #1;
      check("async_reset_flush", {hif.halted, outs}, 9'h000);
      @(negedge CLK);
      nRST = 1'b1;
      #1;
      check("post_reset_run", {hif.halted, outs}, {1'b0, E_ALL});
      @(posedge CLK); #1;
      cyc("post_reset_next", {1'b0, E_ALL});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline control block for the 5-stage MIPS datapath; counterpart to the forwarding unit.
- Handles the hazards the forwarding paths cannot resolve:
  - load-use stalls;
  - data-cache waits;
  - taken-branch/jump flushes;
  - halt.
- Drives per-latch enable/flush and PC enable; sits beside the datapath and samples the ID/EX/MEM stage fields plus the cache hit signals.

Parameters:
- STALL_CNT_W, 16, width of the optional stall statistic counters.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- rs_id  in  5 (regbits_t)  rs of the instruction in ID.
- rt_id  in  5 (regbits_t)  rt of the instruction in ID.
- reg_wr_ex  in  5  destination register of the instruction in EX.
- memread_ex  in  1  instruction in EX is a load.
- dmemren_mem  in  1  MEM stage issues a data read.
- dmemwen_mem  in  1  MEM stage issues a data write.
- ihit  in  1  instruction cache returned data this cycle.
- dhit  in  1  data cache completed the MEM request this cycle.
- pc_redirect_mem  in  1  taken branch or jump resolved in MEM.
- halt_mem  in  1  HALT reached MEM.
- pc_en  out  1  PC update enable.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables.
- ifid_flush, idex_flush, exmem_flush  out  1 each  synchronous latch clears (bubble insert).
- halted  out  1  sticky halt indication.

Behaviour:
- States, encoded as hz_state_t:
  - RUN
  - DWAIT: data access outstanding.
  - FLUSH: redirect seen while frozen; flush owed.
  - HALT
- Async reset (nRST=0):
  - state=RUN;
  - all enables 0, all flushes 0, halted 0;
  - counters 0.
- Outputs are decoded combinationally from state plus inputs. Enables and flushes are 0 whenever nRST=0.
- mem_req = dmemren_mem|dmemwen_mem.
- mem_ok = !mem_req | dhit.
- adv = ihit & mem_ok.
- load_use = memread_ex & (reg_wr_ex!=0) & (reg_wr_ex==rs_id | reg_wr_ex==rt_id).
- RUN:
  - halt_mem & mem_ok:
    - memwb_en=1, all other enables 0;
    - next HALT.
  - mem_req & !dhit:
    - all enables 0, no flush;
    - if pc_redirect_mem, next FLUSH; else next DWAIT.
  - !ihit (no pending mem issue):
    - pc_en, ifid_en, idex_en, exmem_en = 0;
    - memwb_en=1 and exmem_flush=1, so the MEM result retires and no duplicate is produced;
    - state unchanged.
  - adv & pc_redirect_mem:
    - all enables 1;
    - ifid_flush, idex_flush, exmem_flush = 1;
    - the redirect has priority over load_use.
  - adv & load_use:
    - pc_en=0, ifid_en=0;
    - idex_flush=1 (one bubble), exmem_en=memwb_en=1.
  - adv otherwise: all enables 1.
- DWAIT:
  - All enables 0 until dhit.
  - On dhit, evaluate the RUN rules this same cycle (zero extra latency), then return to RUN or the state those rules give.
  - A pc_redirect_mem that rises while in DWAIT moves the next state to FLUSH.
- FLUSH:
  - Enables 0 until adv.
  - On adv: all enables 1 and all three flushes 1; next RUN.
- HALT:
  - All enables 0; halted=1; absorbing until reset.
- Latency:
  - load-use costs exactly 1 bubble;
  - a redirect costs 3 squashed slots;
  - a D-miss of N cycles freezes the pipe N cycles.
- Register 0 never triggers load_use.
- Simultaneous load_use and !dhit: the mem wait wins, and load_use is re-evaluated after dhit.
- Reset mid-DWAIT or mid-FLUSH returns to RUN with the owed flush discarded.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, adds outputs:
  - loaduse_cnt [STALL_CNT_W-1:0]: +1 per load-use bubble;
  - dwait_cnt [STALL_CNT_W-1:0]: +1 per DWAIT cycle;
  - flush_cnt [STALL_CNT_W-1:0]: +1 per redirect flush.
- Counters saturate at all-ones, reset to 0, and freeze in HALT.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- cpu_types_pkg holds:
  - hz_state_t enum;
  - regbits_t (existing);
  - ZERO_REG constant.
- New interface hazard_unit_if, with modports hu and tb, mirroring the forwarding unit's interface.
- Optional sub-module hz_sat_counter (parameterised width, inc, saturating) for the statistic counters.

Test Plan:
- Load-use: reg_wr_ex=5, memread_ex=1, rs_id=5, ihit=1 → pc_en=0, ifid_en=0, idex_flush=1 for 1 cycle; the following cycle all enables are 1.
- Zero-register and no-match cases: reg_wr_ex=0 with rs_id=0, and reg_wr_ex=7 with rs_id=3, rt_id=4 → no stall, all enables 1.
- D-miss: dmemren_mem=1, dhit=0 for 3 cycles then 1 → enables 0 for 3 cycles, 1 on the dhit cycle; dwait_cnt=3 when HAZARD_STATS_EN is defined.
- Redirect: pc_redirect_mem=1 with adv → three flushes asserted for 1 cycle. Redirect during DWAIT → flushes asserted on the dhit cycle.
- Halt: halt_mem=1, no mem req → memwb_en=1 for one cycle, then halted=1 and all enables 0 indefinitely.
- Reset: drop nRST in FLUSH → all outputs 0 asynchronously; after release the state is RUN and no flush is asserted.
